// File: rtl/up_counter_if.sv
// Control/status bundle for up_counter: the driver owns en/load/d/oneshot,
// the counter owns q/tc/wrap/done.
interface up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             oneshot;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (output en, load, d, oneshot, input  q, tc, wrap, done);
  modport slave  (input  en, load, d, oneshot, output q, tc, wrap, done);
endinterface

// File: rtl/up_counter.sv
// Modulo-(MAX+1) up counter with clamped parallel load, one-shot stop at MAX,
// a registered wrap pulse and a combinational terminal-count flag.
module up_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic        clk,
  input  logic        rst,
  up_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic {
    COUNT,
    DONE
  } state_e;

  state_e           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic             wrap, wrap_n;
  logic             done, done_n;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    q_n     = q;
    wrap_n  = 1'b0;

    if (bus.load) begin
      q_n     = (bus.d > MAX_V) ? MAX_V : bus.d;
      state_n = COUNT;
    end else if (bus.en && state == COUNT) begin
      if (q != MAX_V) begin
        q_n = q + ONE;
      end else if (bus.oneshot) begin
        state_n = DONE;
      end else begin
        q_n    = '0;
        wrap_n = 1'b1;
      end
    end

    done_n = (state_n == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COUNT;
      q     <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      wrap  <= wrap_n;
      done  <= done_n;
    end
  end

  assign bus.q    = q;
  assign bus.tc   = (q == MAX_V);
  assign bus.wrap = wrap;
  assign bus.done = done;

endmodule

// File: tb/tb_up_counter.sv
// Drives three up_counter instances (MAX = 15, 9, 1) with shared stimulus and
// checks each against an arithmetic reference model.
module tb_up_counter;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst, en, load, oneshot;
  logic [W-1:0] d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  up_counter_if #(.WIDTH(W)) bus0 ();
  up_counter_if #(.WIDTH(W)) bus1 ();
  up_counter_if #(.WIDTH(W)) bus2 ();

  assign bus0.en = en;  assign bus0.load = load;  assign bus0.d = d;  assign bus0.oneshot = oneshot;
  assign bus1.en = en;  assign bus1.load = load;  assign bus1.d = d;  assign bus1.oneshot = oneshot;
  assign bus2.en = en;  assign bus2.load = load;  assign bus2.d = d;  assign bus2.oneshot = oneshot;

  up_counter #(.WIDTH(W), .MAX(15)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  up_counter #(.WIDTH(W), .MAX(9))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  up_counter #(.WIDTH(W), .MAX(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Observed {q, tc, wrap, done} per instance.
  logic [W+2:0] obs [N];
  assign obs[0] = {bus0.q, bus0.tc, bus0.wrap, bus0.done};
  assign obs[1] = {bus1.q, bus1.tc, bus1.wrap, bus1.done};
  assign obs[2] = {bus2.q, bus2.tc, bus2.wrap, bus2.done};

  // Reference model: plain integer count with a stopped flag.
  int maxv   [N] = '{15, 9, 1};
  int m_q    [N];
  bit m_wrap [N];
  bit m_done [N];

  function automatic logic [W+2:0] expect_sig(int k);
    return {W'(m_q[k]), 1'(m_q[k] == maxv[k]), m_wrap[k], m_done[k]};
  endfunction

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      m_wrap[k] = 1'b0;
      if (rst) begin
        m_q[k]    = 0;
        m_done[k] = 1'b0;
      end else if (load) begin
        m_q[k]    = (int'(d) > maxv[k]) ? maxv[k] : int'(d);
        m_done[k] = 1'b0;
      end else if (en && !m_done[k]) begin
        if (m_q[k] == maxv[k] && oneshot) begin
          m_done[k] = 1'b1;
        end else begin
          m_q[k]    = (m_q[k] + 1) % (maxv[k] + 1);
          m_wrap[k] = (m_q[k] == 0);
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, settle 1 time unit past the edge.
  task automatic step(input logic r, input logic l, input logic e,
                      input logic os, input logic [W-1:0] dv);
    rst = r; load = l; en = e; oneshot = os; d = dv;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k] !== expect_sig(k)) begin
        failures++;
        $display("FAIL reset dut%0d: got %b expected %b", k, obs[k], expect_sig(k));
      end
    end
    checks++;
    if (bus0.q !== 4'd0 || bus0.wrap !== 1'b0 || bus0.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got q=%0d wrap=%b done=%b expected 0 0 0", bus0.q, bus0.wrap, bus0.done);
    end
  endtask

  task automatic test_wrap_count();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (bus0.q !== 4'((i + 1) % 16) || bus0.wrap !== (i == 15) || bus0.tc !== (i == 14)) begin
        failures++;
        $display("FAIL wrap_count step %0d: got q=%0d wrap=%b tc=%b expected q=%0d wrap=%b tc=%b",
                 i, bus0.q, bus0.wrap, bus0.tc, (i + 1) % 16, (i == 15), (i == 14));
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs[k] !== expect_sig(k)) begin
          failures++;
          $display("FAIL wrap_count dut%0d: got %b expected %b", k, obs[k], expect_sig(k));
        end
      end
    end
  endtask

  task automatic test_oneshot();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs[k] !== expect_sig(k)) begin
          failures++;
          $display("FAIL oneshot dut%0d cyc %0d: got %b expected %b", k, i, obs[k], expect_sig(k));
        end
      end
      if (i >= 8) begin
        checks++;
        if (bus1.q !== 4'd9 || bus1.done !== (i >= 9)) begin
          failures++;
          $display("FAIL oneshot_hold cyc %0d: got q=%0d done=%b expected q=9 done=%b",
                   i, bus1.q, bus1.done, (i >= 9));
        end
      end
    end
    // Dropping oneshot while stopped must not restart counting.
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus1.q !== 4'd9 || bus1.done !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_drop: got q=%0d done=%b expected q=9 done=1", bus1.q, bus1.done);
    end
  endtask

  task automatic test_done_load();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    checks++;
    if (bus1.q !== 4'd3 || bus1.done !== 1'b0) begin
      failures++;
      $display("FAIL done_load: got q=%0d done=%b expected q=3 done=0", bus1.q, bus1.done);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (bus1.q !== 4'(4 + i)) begin
        failures++;
        $display("FAIL done_load_count %0d: got q=%0d expected %0d", i, bus1.q, 4 + i);
      end
    end
  endtask

  task automatic test_load_clamp();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd12);
    checks++;
    if (bus0.q !== 4'd12 || bus1.q !== 4'd9 || bus2.q !== 4'd1) begin
      failures++;
      $display("FAIL load_clamp: got q=%0d/%0d/%0d expected 12/9/1", bus0.q, bus1.q, bus2.q);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
    checks++;
    if (bus0.q !== 4'd7 || bus1.q !== 4'd7 || bus2.q !== 4'd1) begin
      failures++;
      $display("FAIL load_seven: got q=%0d/%0d/%0d expected 7/7/1", bus0.q, bus1.q, bus2.q);
    end
  endtask

  task automatic test_rst_priority();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus1.q !== 4'd6) begin
      failures++;
      $display("FAIL rst_setup: got q=%0d expected 6", bus1.q);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k][W+2:3] !== '0 || obs[k][1:0] !== 2'b00) begin
        failures++;
        $display("FAIL rst_priority dut%0d: got %b expected q=0 wrap=0 done=0", k, obs[k]);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus1.q !== 4'd1) begin
      failures++;
      $display("FAIL rst_resume: got q=%0d expected 1", bus1.q);
    end
  endtask

  task automatic test_en_toggle();
    int wraps = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 1'(i % 2 == 0), 1'b0, '0);
      if (bus0.wrap === 1'b1) wraps++;
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs[k] !== expect_sig(k)) begin
          failures++;
          $display("FAIL en_toggle dut%0d cyc %0d: got %b expected %b", k, i, obs[k], expect_sig(k));
        end
      end
    end
    checks++;
    if (bus0.q !== 4'd0 || wraps != 1) begin
      failures++;
      $display("FAIL en_toggle_end: got q=%0d wraps=%0d expected q=0 wraps=1", bus0.q, wraps);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (bus2.wrap !== (i % 2 == 1) || bus2.q !== 4'((i + 1) % 2)) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: got q=%0d wrap=%b expected q=%0d wrap=%b",
                 i, bus2.q, bus2.wrap, (i + 1) % 2, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(31) == 0), 1'($urandom_range(7) == 0),
           1'($urandom_range(3) != 0), 1'($urandom_range(1)), W'($urandom_range(15)));
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs[k] !== expect_sig(k)) begin
          failures++;
          $display("FAIL random dut%0d cyc %0d: got %b expected %b", k, i, obs[k], expect_sig(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; oneshot = 1'b0; d = '0;
    test_reset();
    test_wrap_count();
    test_oneshot();
    test_done_load();
    test_load_clamp();
    test_rst_priority();
    test_en_toggle();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
